sel_encode_scoreboard: RTL and testbench
========================================

// Module: sel_encode_scoreboard
// PURPOSE
//  Parametrised select-and-encode unit for the register file, with a pending-write scoreboard.
//  - Decodes IR register fields into one-hot RegIn/RegOut enables and sign-extends the C field.
//  - Tracks registers with outstanding writebacks and gates instruction issue on RAW/WAW hazards.
//  - Sits between the control unit and the register file; issue handshake faces the control unit.
// PARAMETERS
//  NUM_REGS   16  number of GP registers (power of 2, 2..64)
//  IDX_W      $clog2(NUM_REGS)  register index width (derived localparam)
//  IR_W       32  instruction register width
//  RA_LSB     23  LSB of Ra field in IR (field is IDX_W bits)
//  RB_LSB     19  LSB of Rb field in IR
//  RC_LSB     15  LSB of Rc field in IR
//  IMM_W      19  width of C immediate, IR[IMM_W-1:0], sign-extended to IR_W
// PORTS
//  clock        in   1         rising-edge clock
//  clear        in   1         asynchronous, active-high reset
//  IR           in   IR_W      instruction register contents
//  Gra/Grb/Grc  in   1 each    select Ra/Rb/Rc field for the decoder
//  Rin/Rout/BAout in 1 each    register-file write / read / base-address-read strobes
//  RegIn        out  NUM_REGS  one-hot write enable
//  RegOut       out  NUM_REGS  one-hot read enable
//  ba_zero      out  1         BAout on R0: bus must be driven with 0
//  C_sign_extended out IR_W    sign-extended immediate
//  issue_valid  in   1         control unit requests issue of IR
//  issue_wr     in   1         issued instr writes Ra (0: store/branch, no dest)
//  issue_ready  out  1         issue may be accepted this cycle
//  wb_valid     in   1         writeback completing this cycle
//  wb_idx       in   IDX_W     register being written back
//  pending      out  NUM_REGS  scoreboard bits (registered)
//  pend_cnt     out  IDX_W+1   population count of pending (registered)
//  err_spur_wb  out  1         one-cycle pulse: writeback to non-pending register
// BEHAVIOUR
//  Select/encode (combinational, zero latency):
//  - idx = (Gra?Ra:0)|(Grb?Rb:0)|(Grc?Rc:0).
//  - RegIn = Rin ? (1<<idx) : 0; RegOut = (Rout|BAout) ? (1<<idx) : 0.
//  - Exception: BAout & idx==0 -> RegOut=0, ba_zero=1; else ba_zero=0.
//  - C_sign_extended = {{(IR_W-IMM_W){IR[IMM_W-1]}}, IR[IMM_W-1:0]}.
//  Scoreboard (sequential):
//  - clear: pending=0, pend_cnt=0, err_spur_wb=0 immediately; comb outputs follow inputs.
//  - eff_pend = pending & ~(wb_valid ? 1<<wb_idx : 0) (same-cycle writeback forwards).
//  - hazard = eff_pend[Ra] (WAW, only if issue_wr) | eff_pend[Rb] | eff_pend[Rc].
//    Rb/Rc are always checked; a spurious stall is acceptable.
//  - issue_ready = ~hazard; combinational, independent of issue_valid.
//  - Accept = issue_valid & issue_ready; if Accept & issue_wr, set pending[Ra] at next edge.
//  - wb_valid clears pending[wb_idx] at next edge.
//  - Simultaneous set and clear of the same index: set wins; the bit stays 1.
//  - wb_valid with pending[wb_idx]==0: no state change; err_spur_wb=1 for the next cycle only.
//  - pend_cnt is registered with pending and always equals popcount(pending); never overflows.
//  - clear asserted mid-operation drops all outstanding entries; later writebacks flag err_spur_wb.
// TESTING
//  - Reset: assert clear -> pending=0, pend_cnt=0, issue_ready=1, err_spur_wb=0.
//  - Decode: IR Ra=5, Gra=1, Rin=1 -> RegIn=16'h0020, RegOut=0.
//    Same IR with Rout=1 instead -> RegOut=16'h0020.
//  - BAout on R0: Rb=0, Grb=1, BAout=1 -> RegOut=0, ba_zero=1.
//    Rb=3 -> RegOut=16'h0008, ba_zero=0.
//  - Immediate: IR[18:0]=19'h40000 -> C=32'hFFFC0000.
//    IR[18:0]=19'h00005 -> C=32'h00000005.
//  - RAW/WAW: issue Ra=4 with issue_wr -> pending=16'h0010, pend_cnt=1.
//    Next instr with Rb=4 -> issue_ready=0.
//    wb_valid with wb_idx=4 in the same cycle -> issue_ready=1.
//    Next edge -> pend_cnt=0.
//  - Set/clear collision: pending[7]=1; wb_idx=7 and issue Ra=7 in the same cycle -> pending[7]=1.
//    Then wb_idx=9 on a clear scoreboard -> err_spur_wb pulses for exactly 1 cycle.

Source files
------------

// File: rtl/sel_encode_scoreboard.sv
// Register-file select/encode unit with a pending-write scoreboard.
// The decoder turns the IR register fields into one-hot read/write enables
// and sign-extends the C immediate. The scoreboard records registers that
// have outstanding writebacks and holds off issue on RAW/WAW hazards.
module sel_encode_scoreboard #(
    parameter int  NUM_REGS = 16,
    parameter int  IR_W     = 32,
    parameter int  RA_LSB   = 23,
    parameter int  RB_LSB   = 19,
    parameter int  RC_LSB   = 15,
    parameter int  IMM_W    = 19,
    localparam int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic                clock,
    input  logic                clear,
    input  logic [IR_W-1:0]     IR,
    input  logic                Gra,
    input  logic                Grb,
    input  logic                Grc,
    input  logic                Rin,
    input  logic                Rout,
    input  logic                BAout,
    output logic [NUM_REGS-1:0] RegIn,
    output logic [NUM_REGS-1:0] RegOut,
    output logic                ba_zero,
    output logic [IR_W-1:0]     C_sign_extended,
    input  logic                issue_valid,
    input  logic                issue_wr,
    output logic                issue_ready,
    input  logic                wb_valid,
    input  logic [IDX_W-1:0]    wb_idx,
    output logic [NUM_REGS-1:0] pending,
    output logic [IDX_W:0]      pend_cnt,
    output logic                err_spur_wb
);

    // Decoded one-hot vector for a register index.
    function automatic logic [NUM_REGS-1:0] onehot(input logic [IDX_W-1:0] i);
        logic [NUM_REGS-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Number of set bits; NUM_REGS fits in IDX_W+1 bits so it cannot wrap.
    function automatic logic [IDX_W:0] popcount(input logic [NUM_REGS-1:0] v);
        logic [IDX_W:0] c;
        c = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            c = c + (IDX_W+1)'(v[k]);
        end
        return c;
    endfunction

    logic [IDX_W-1:0]    ra;
    logic [IDX_W-1:0]    rb;
    logic [IDX_W-1:0]    rc;
    logic [IDX_W-1:0]    sel_idx;
    logic [NUM_REGS-1:0] sel_oh;
    logic                ba_r0;
    logic [NUM_REGS-1:0] wb_oh;
    logic [NUM_REGS-1:0] eff_pend;
    logic                hazard;
    logic                accept;
    logic [NUM_REGS-1:0] set_oh;
    logic [NUM_REGS-1:0] pend_nxt;
    logic                spur;
    logic                unused_ir;

    // Only the register fields and the immediate are decoded here.
    assign unused_ir = ^IR;

    // Field select and one-hot encode towards the register file.
    always_comb begin
        ra      = IR[RA_LSB +: IDX_W];
        rb      = IR[RB_LSB +: IDX_W];
        rc      = IR[RC_LSB +: IDX_W];
        sel_idx = ({IDX_W{Gra}} & ra) | ({IDX_W{Grb}} & rb) | ({IDX_W{Grc}} & rc);
        sel_oh  = onehot(sel_idx);
        // Base-address read of R0 means "address base zero", not the R0 contents.
        ba_r0   = BAout && (sel_idx == '0);
        RegIn   = Rin ? sel_oh : '0;
        RegOut  = ((Rout || BAout) && !ba_r0) ? sel_oh : '0;
        ba_zero = ba_r0;
        C_sign_extended = {{(IR_W-IMM_W){IR[IMM_W-1]}}, IR[IMM_W-1:0]};
    end

    // Hazard detection and next scoreboard state.
    always_comb begin
        wb_oh    = wb_valid ? onehot(wb_idx) : '0;
        // A writeback landing this cycle already frees its register for issue.
        eff_pend = pending & ~wb_oh;
        // Rb/Rc are checked even for instructions that do not read them; the
        // occasional needless stall keeps the check free of opcode decode.
        hazard   = (issue_wr && eff_pend[ra]) || eff_pend[rb] || eff_pend[rc];
        issue_ready = !hazard;
        accept   = issue_valid && !hazard;
        set_oh   = (accept && issue_wr) ? onehot(ra) : '0;
        // Set is applied after clear so a same-index collision keeps the bit.
        pend_nxt = (pending & ~wb_oh) | set_oh;
        spur     = wb_valid && !pending[wb_idx];
    end

    // Scoreboard state, its population count and the spurious-writeback flag.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            pending     <= '0;
            pend_cnt    <= '0;
            err_spur_wb <= 1'b0;
        end else begin
            pending     <= pend_nxt;
            pend_cnt    <= popcount(pend_nxt);
            err_spur_wb <= spur;
        end
    end

endmodule

// File: tb/tb_sel_encode_scoreboard.sv
// Bench for sel_encode_scoreboard: directed stimulus pushes expected values
// into a queue, a monitor pops and compares them on the falling clock edge.
module tb_sel_encode_scoreboard;

    localparam int NR = 16;

    logic          clock = 1'b0;
    logic          clear;
    logic [31:0]   IR;
    logic          Gra, Grb, Grc, Rin, Rout, BAout;
    logic [NR-1:0] RegIn, RegOut;
    logic          ba_zero;
    logic [31:0]   C_sign_extended;
    logic          issue_valid, issue_wr, issue_ready;
    logic          wb_valid;
    logic [3:0]    wb_idx;
    logic [NR-1:0] pending;
    logic [4:0]    pend_cnt;
    logic          err_spur_wb;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
    } exp_t;

    exp_t sbq[$];

    sel_encode_scoreboard dut (
        .clock(clock), .clear(clear), .IR(IR),
        .Gra(Gra), .Grb(Grb), .Grc(Grc),
        .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .RegIn(RegIn), .RegOut(RegOut), .ba_zero(ba_zero),
        .C_sign_extended(C_sign_extended),
        .issue_valid(issue_valid), .issue_wr(issue_wr), .issue_ready(issue_ready),
        .wb_valid(wb_valid), .wb_idx(wb_idx),
        .pending(pending), .pend_cnt(pend_cnt), .err_spur_wb(err_spur_wb)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mk_ir(input int ra, input int rb, input int rc,
                                          input logic [18:0] imm);
        logic [31:0] v;
        v = 32'(ra) << 23 | 32'(rb) << 19 | 32'(rc) << 15 | {13'b0, imm};
        return v;
    endfunction

    function automatic logic [31:0] actual(input int kind);
        case (kind)
            0: return {16'b0, RegIn};
            1: return {16'b0, RegOut};
            2: return {31'b0, ba_zero};
            3: return C_sign_extended;
            4: return {31'b0, issue_ready};
            5: return {16'b0, pending};
            6: return {27'b0, pend_cnt};
            default: return {31'b0, err_spur_wb};
        endcase
    endfunction

    task automatic push(input string n, input int k, input logic [31:0] v);
        exp_t e;
        e.name = n;
        e.kind = k;
        e.exp  = v;
        sbq.push_back(e);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic quiet();
        Gra = 0; Grb = 0; Grc = 0; Rin = 0; Rout = 0; BAout = 0;
        issue_valid = 0; issue_wr = 0; wb_valid = 0; wb_idx = '0;
    endtask

    // Monitor: compare every queued expectation against the settled outputs.
    always @(negedge clock) begin
        while (sbq.size() > 0) begin
            exp_t e;
            logic [31:0] a;
            e = sbq.pop_front();
            a = actual(e.kind);
            n_checks++;
            if (a === e.exp) n_pass++;
            else $display("FAIL %s: got %h, expected %h", e.name, a, e.exp);
        end
    end

    initial begin
        clear = 1'b1;
        IR    = '0;
        quiet();

        // Reset state
        step();
        push("rst_pending", 5, 32'h0);
        push("rst_cnt", 6, 32'h0);
        push("rst_ready", 4, 32'h1);
        push("rst_err", 7, 32'h0);
        step();
        clear = 1'b0;

        // Decode Ra=5 with Rin, then with Rout
        IR = mk_ir(5, 0, 0, 19'h0); Gra = 1; Rin = 1;
        push("dec_regin", 0, 32'h0020);
        push("dec_regout0", 1, 32'h0);
        step();
        Rin = 0; Rout = 1;
        push("dec_regout", 1, 32'h0020);
        push("dec_regin0", 0, 32'h0);
        step();

        // BAout on R0 and on R3
        quiet();
        IR = mk_ir(5, 0, 0, 19'h0); Grb = 1; BAout = 1;
        push("ba_r0_regout", 1, 32'h0);
        push("ba_r0_zero", 2, 32'h1);
        step();
        IR = mk_ir(5, 3, 0, 19'h0);
        push("ba_r3_regout", 1, 32'h0008);
        push("ba_r3_zero", 2, 32'h0);
        step();

        // Immediate sign extension
        quiet();
        IR = mk_ir(0, 0, 0, 19'h40000);
        push("imm_neg", 3, 32'hFFFC0000);
        step();
        IR = mk_ir(0, 0, 0, 19'h00005);
        push("imm_pos", 3, 32'h00000005);
        step();

        // RAW: issue write to R4, then reader of R4 stalls until writeback
        IR = mk_ir(4, 0, 0, 19'h0); issue_valid = 1; issue_wr = 1;
        push("raw_issue_ready", 4, 32'h1);
        step();
        IR = mk_ir(1, 4, 0, 19'h0);
        push("raw_pending", 5, 32'h0010);
        push("raw_cnt", 6, 32'h1);
        push("raw_stall", 4, 32'h0);
        step();
        issue_valid = 0; wb_valid = 1; wb_idx = 4'd4;
        push("raw_fwd_ready", 4, 32'h1);
        push("raw_still_pend", 5, 32'h0010);
        step();
        quiet();
        push("raw_cnt_done", 6, 32'h0);
        push("raw_pend_done", 5, 32'h0);
        push("raw_no_err", 7, 32'h0);
        step();

        // Set/clear collision on R7
        IR = mk_ir(7, 0, 0, 19'h0); issue_valid = 1; issue_wr = 1;
        step();
        wb_valid = 1; wb_idx = 4'd7;
        push("col_pend_before", 5, 32'h0080);
        push("col_ready", 4, 32'h1);
        step();
        issue_valid = 0; issue_wr = 0;
        push("col_pend_kept", 5, 32'h0080);
        push("col_cnt_kept", 6, 32'h1);
        push("col_no_err", 7, 32'h0);
        step();
        wb_valid = 0;
        push("col_cleared", 5, 32'h0);

        // Spurious writeback to R9 pulses the error for one cycle
        step();
        wb_valid = 1; wb_idx = 4'd9;
        step();
        wb_valid = 0;
        push("spur_pulse", 7, 32'h1);
        push("spur_pend", 5, 32'h0);
        step();
        push("spur_one_cycle", 7, 32'h0);

        // WAW only when the instruction writes; then clear drops the entry
        IR = mk_ir(2, 0, 0, 19'h0); issue_valid = 1; issue_wr = 1;
        step();
        issue_valid = 0; issue_wr = 0;
        push("waw_nowr_ready", 4, 32'h1);
        push("waw_pend", 5, 32'h0004);
        step();
        issue_wr = 1;
        push("waw_stall", 4, 32'h0);
        step();
        issue_wr = 0; clear = 1;
        push("clr_pending", 5, 32'h0);
        push("clr_cnt", 6, 32'h0);
        step();
        clear = 0; wb_valid = 1; wb_idx = 4'd2;
        step();
        wb_valid = 0;
        push("clr_late_wb_err", 7, 32'h1);
        step();

        // Drain the queue with a bounded wait
        for (int i = 0; i < 10 && sbq.size() > 0; i++) @(posedge clock);
        if (sbq.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, expected 0", sbq.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
